// File: rtl/wb_arbiter_n.sv
// N-master Wishbone arbiter: round-robin grant, locked bursts,
// zero-cycle handover and an optional slave-stall timeout.
module wb_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic                                m_int_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  input  logic                                s_int_i,
  output logic [NUM_MASTERS-1:0]              grant_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    ABORT
  } state_t;

  state_t state_q, state_d;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] req, pick_oh;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] base, pick;
  logic [CW-1:0] cnt_q;
  logic pick_ok;
  logic own_cyc, own_stb, owned;
  logic err_q, err_d, tmo;

  assign owned   = (state_q == OWNED);
  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = m_stb_i[owner_q];

  assign s_cyc_o = owned & own_cyc;
  assign s_stb_o = owned & own_cyc & own_stb;
  assign s_we_o  = owned & m_we_i[owner_q];
  assign s_sel_o = m_sel_i[int'(owner_q)*SW +: SW];
  assign s_adr_o = m_adr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_dat_o = m_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

  assign m_dat_o = s_dat_i;
  assign m_int_o = s_int_i;
  assign grant_o = grant_q;
  assign m_ack_o = grant_q & {NUM_MASTERS{owned & s_ack_i}};
  assign m_err_o = grant_q & {NUM_MASTERS{(state_q == ABORT) & err_q}};

  assign tmo = TMO_EN && (cnt_q == '0) && s_stb_o && !s_ack_i;

  // Search starts after the releasing owner, or after last_owner when idle.
  assign base = (state_q == IDLE) ? last_q : owner_q;
  assign req  = m_cyc_i & ~grant_q;

  always_comb begin
    int j;
    pick    = '0;
    pick_oh = '0;
    pick_ok = 1'b0;
    j       = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      j = (int'(base) + k) % NUM_MASTERS;
      if (req[j]) begin
        pick_ok = 1'b1;
        pick    = IW'(j);
        pick_oh = '0;
        pick_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = OWNED;
          grant_d = pick_oh;
          owner_d = pick;
        end
      end
      OWNED, ABORT: begin
        if (!own_cyc) begin
          last_d = owner_q;
          if (pick_ok) begin
            state_d = OWNED;
            grant_d = pick_oh;
            owner_d = pick;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (owned && tmo) begin
          state_d = ABORT;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Reloads whenever the slave is not being stalled.
  always_ff @(posedge clk) begin
    if (rst || !s_stb_o || s_ack_i) begin
      cnt_q <= CW'(TIMEOUT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n with four masters, one instance
// with TIMEOUT=4 and one with the timeout disabled.
module tb_wb_arbiter_n;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [N*DW/8-1:0] m_sel;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack, s_int;

  logic [DW-1:0]   m_dat_o, m_dat_o0;
  logic [N-1:0]    m_ack, m_ack0, m_err, m_err0, grant, grant0;
  logic            m_int, m_int0;
  logic            s_cyc, s_cyc0, s_stb, s_stb0, s_we, s_we0;
  logic [DW/8-1:0] s_sel, s_sel0;
  logic [AW-1:0]   s_adr, s_adr0;
  logic [DW-1:0]   s_dat, s_dat0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_arbiter_n #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)
  ) u_dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .m_int_o(m_int),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_int_i(s_int),
    .grant_o(grant)
  );

  wb_arbiter_n #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o0), .m_ack_o(m_ack0), .m_err_o(m_err0),
    .m_int_o(m_int0),
    .s_cyc_o(s_cyc0), .s_stb_o(s_stb0), .s_we_o(s_we0),
    .s_sel_o(s_sel0), .s_adr_o(s_adr0), .s_dat_o(s_dat0),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_int_i(s_int),
    .grant_o(grant0)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] adr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  int ack2, acko, errs;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW] = adr_of(i);
      m_dat[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      m_sel[i*4 +: 4]   = 4'(i + 1);
    end
    m_we = 4'b0100;
    s_dat_i = 32'hCAFE_F00D;
    s_int = 1'b0;
    rst = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    step();
    step();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_scyc", 64'(s_cyc), 64'h0);
    chk("rst_ack_err", 64'({m_ack, m_err}), 64'h0);
    rst = 1'b0;

    // first grant from 0101, then direct handover to master 2
    m_cyc = 4'b0101;
    m_stb = 4'b0101;
    #1;
    chk("pre_grant", 64'(grant), 64'h0);
    step();
    #1;
    chk("grant_m0", 64'(grant), 64'h1);
    chk("scyc_m0", 64'(s_cyc), 64'h1);
    chk("adr_m0", 64'(s_adr), 64'(adr_of(0)));
    s_ack = 1'b1;
    s_int = 1'b1;
    #1;
    chk("ack_m0", 64'(m_ack), 64'h1);
    chk("dat_bcast", 64'(m_dat_o), 64'hCAFE_F00D);
    chk("int_bcast", 64'(m_int), 64'h1);
    m_cyc = 4'b0100;
    m_stb = 4'b0100;
    s_ack = 1'b0;
    s_int = 1'b0;
    step();
    #1;
    chk("handover_m2", 64'(grant), 64'h4);
    chk("adr_m2", 64'(s_adr), 64'(adr_of(2)));
    chk("we_dat_m2", 64'({s_we, s_dat}), 64'h1_D000_0002);
    chk("sel_m2", 64'(s_sel), 64'h3);
    chk("int_low", 64'(m_int), 64'h0);
    m_cyc = '0;
    m_stb = '0;
    step();
    chk("release_idle", 64'(grant), 64'h0);

    // fairness: everyone requests, owner leaves after one acked beat
    do_reset();
    m_cyc = 4'b1111;
    m_stb = 4'b1111;
    s_ack = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 64'(grant), 64'(1 << (k % 4)));
      chk($sformatf("rr_ack%0d", k), 64'(m_ack), 64'(1 << (k % 4)));
      m_cyc = ~grant;
      m_stb = ~grant;
      step();
      m_cyc = 4'b1111;
      m_stb = 4'b1111;
    end

    // locked burst by master 2 while master 1 waits
    do_reset();
    m_cyc = 4'b0100;
    m_stb = 4'b0100;
    step();
    m_cyc = 4'b0110;
    m_stb = 4'b0110;
    s_ack = 1'b1;
    ack2 = 0;
    acko = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (m_ack[2]) ack2++;
      if ((m_ack & 4'b1011) != 0) acko++;
      step();
    end
    chk("burst_ack2", 64'(ack2), 64'd8);
    chk("burst_acko", 64'(acko), 64'd0);
    m_cyc = 4'b0010;
    m_stb = 4'b0010;
    s_ack = 1'b0;
    #1;
    chk("burst_held", 64'(grant), 64'h4);
    step();
    chk("burst_next_m1", 64'(grant), 64'h2);

    // timeout of 4: one err pulse five cycles after first stall
    do_reset();
    m_cyc = 4'b1000;
    m_stb = 4'b1000;
    step();
    errs = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) chk("tmo_stb", 64'(s_stb), 64'h1);
      if (m_err[3]) errs++;
      if (c == 5) chk("tmo_err_at5", 64'(m_err), 64'h8);
      if (c == 6) chk("tmo_scyc_abort", 64'({s_cyc, s_stb}), 64'h0);
      step();
    end
    chk("tmo_one_pulse", 64'(errs), 64'd1);
    chk("tmo_still_owned", 64'(grant), 64'h8);
    m_cyc = '0;
    m_stb = '0;
    step();
    chk("tmo_release", 64'(grant), 64'h0);

    // timeout disabled: long stall then ack
    do_reset();
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    step();
    errs = 0;
    for (int c = 0; c < 200; c++) begin
      if (m_err0 != 0) errs++;
      step();
    end
    s_ack = 1'b1;
    #1;
    chk("notmo_err", 64'(errs), 64'd0);
    chk("notmo_ack", 64'(m_ack0), 64'h1);

    // reset mid burst after round-robin moved the pointer
    do_reset();
    m_cyc = 4'b0110;
    m_stb = 4'b0110;
    step();
    chk("mid_grant_m1", 64'(grant), 64'h2);
    m_cyc = 4'b0100;
    step();
    m_cyc = 4'b0110;
    m_stb = 4'b0110;
    s_ack = 1'b1;
    #1;
    chk("mid_owner_m2", 64'(m_ack), 64'h4);
    rst = 1'b1;
    step();
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_scyc", 64'(s_cyc), 64'h0);
    chk("mid_rst_ackerr", 64'({m_ack, m_err}), 64'h0);
    rst = 1'b0;
    s_ack = 1'b0;
    m_cyc = 4'b0111;
    m_stb = 4'b0111;
    step();
    chk("post_rst_m0", 64'(grant), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
